ram_key_arbiter: RTL and testbench

- Shares the single-port data RAM between the MIPS core data port and the keyboard scan/ASCII writer.
- The CPU has priority. Key writes are buffered in a small FIFO and drained into RAM on idle CPU cycles.
- If the CPU stays busy too long, a one-cycle CPU stall is forced so the keyboard is never starved.
- Sits between the core/keyboard controller and the data RAM, replacing the RAM's direct key-write path.

---
 rtl/ram_key_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_key_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_key_arbiter.sv
// Data RAM arbiter: CPU port has priority, key writes buffered and drained on idle cycles.
// Optional store-to-load forwarding from the key FIFO when RAM_KEY_ARB_FWD_EN is defined.
module ram_key_arbiter #(
  parameter int FIFO_LOG2    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          cpu_addr,
  input  logic                 cpu_re,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 key_valid,
  input  logic [11:0]          key_addr,
  input  logic [31:0]          key_wdata,
  output logic                 key_ready,
  output logic [FIFO_LOG2:0]   key_pending,
  output logic                 key_overflow,
  input  logic                 ovf_clr,
  output logic [11:0]          ram_addr,
  output logic                 ram_write_enable,
  output logic [31:0]          ram_write_data,
  input  logic [31:0]          ram_read_data
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = $clog2(STARVE_LIMIT) + 1;
  localparam logic [FIFO_LOG2:0] FULL = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0] ONE  = (FIFO_LOG2+1)'(1);
  localparam logic [CW-1:0]      LIM1 = CW'(STARVE_LIMIT - 1);
  localparam logic [CW-1:0]      CONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FORCE
  } state_t;

  logic [11:0]          fa [DEPTH];
  logic [31:0]          fd [DEPTH];
  logic [FIFO_LOG2-1:0] head, tail;
  logic [FIFO_LOG2:0]   count, count_nx;
  logic [CW-1:0]        starve, starve_nx;
  state_t               state, state_nx;
  logic                 push, pop, grant, nonempty;

  assign nonempty = count != '0;
  assign grant    = nonempty & ((state == S_FORCE) | (!cpu_re & !cpu_we));
  assign push     = key_valid & key_ready;
  assign pop      = grant;

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + ONE;
    else if (!push && pop)
      count_nx = count - ONE;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa[tail] <= key_addr;
      fd[tail] <= key_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      key_ready    <= 1'b0;
      key_overflow <= 1'b0;
      starve       <= '0;
      state        <= S_IDLE;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count     <= count_nx;
      key_ready <= count_nx != FULL;
      if (key_valid && !key_ready)
        key_overflow <= 1'b1;
      else if (ovf_clr)
        key_overflow <= 1'b0;
      starve <= starve_nx;
      state  <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    starve_nx = starve;
    unique case (state)
      S_IDLE: begin
        starve_nx = '0;
        if (count_nx != '0) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (grant) begin
          starve_nx = '0;
        end else if (nonempty) begin
          starve_nx = starve + CONE;
          if (starve_nx == LIM1) state_nx = S_FORCE;
        end
        if (count_nx == '0) begin
          starve_nx = '0;
          state_nx  = S_IDLE;
        end
      end
      S_FORCE: begin
        starve_nx = '0;
        state_nx  = (count_nx != '0) ? S_WAIT : S_IDLE;
      end
      default: begin
        starve_nx = '0;
        state_nx  = S_IDLE;
      end
    endcase
  end

  assign key_pending      = count;
  assign cpu_stall        = state == S_FORCE;
  assign ram_addr         = grant ? fa[head] : cpu_addr;
  assign ram_write_data   = grant ? fd[head] : cpu_wdata;
  assign ram_write_enable = rst_n & (grant | cpu_we);

`ifdef RAM_KEY_ARB_FWD_EN
  logic [FIFO_LOG2-1:0] idx;
`endif

  always_comb begin
    cpu_rdata = ram_read_data;
`ifdef RAM_KEY_ARB_FWD_EN
    idx = head;
    // oldest to youngest, so the last match is the youngest entry
    if (cpu_re && !grant) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + FIFO_LOG2'(i);
        if (((FIFO_LOG2+1)'(i) < count) &&
            (fa[idx][11:2] == cpu_addr[11:2]))
          cpu_rdata = fd[idx];
      end
    end
`endif
    if (state == S_FORCE) cpu_rdata = '0;
  end

endmodule

// File: tb/tb_ram_key_arbiter.sv
// Bench for ram_key_arbiter: RAM model, write scoreboard, directed scenarios.
// Expects the forwarded value only when RAM_KEY_ARB_FWD_EN is defined.
module tb_ram_key_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        key_valid = 1'b0;
  logic [11:0] key_addr = '0;
  logic [31:0] key_wdata = '0;
  logic        key_ready;
  logic [2:0]  key_pending;
  logic        key_overflow;
  logic        ovf_clr = 1'b0;
  logic [11:0] ram_addr;
  logic        ram_write_enable;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] mem [1024];
  int          n_chk = 0;
  int          n_pass = 0;
  int          stalls;

  ram_key_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_addr         (cpu_addr),
    .cpu_re           (cpu_re),
    .cpu_we           (cpu_we),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_stall        (cpu_stall),
    .key_valid        (key_valid),
    .key_addr         (key_addr),
    .key_wdata        (key_wdata),
    .key_ready        (key_ready),
    .key_pending      (key_pending),
    .key_overflow     (key_overflow),
    .ovf_clr          (ovf_clr),
    .ram_addr         (ram_addr),
    .ram_write_enable (ram_write_enable),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  always #5 clk = ~clk;

  assign ram_read_data = mem[ram_addr[11:2]];

  always @(posedge clk)
    if (ram_write_enable) mem[ram_addr[11:2]] <= ram_write_data;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (key_pending != 3'd0 && n < 20) begin
      tick();
      n++;
    end
    check("drain", 32'(key_pending), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_we", 32'(ram_write_enable), 32'd0);
    end else if (ram_write_enable) begin
      if (exp_q.size() == 0) begin
        check("unexp_wr", 32'(ram_write_enable), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(mon_e.a));
        check("wr_data", ram_write_data, mon_e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_rdy", 32'(key_ready), 32'd0);
    check("rst_pend", 32'(key_pending), 32'd0);
    check("rst_ovf", 32'(key_overflow), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_pre", 32'(key_ready), 32'd0);
    tick();
    @(negedge clk);
    check("rdy_post", 32'(key_ready), 32'd1);

    // single key write, CPU idle
    tick();
    key_valid = 1'b1;
    key_addr  = 12'h310;
    key_wdata = 32'h41;
    push_exp(12'h310, 32'h41);
    tick();
    key_valid = 1'b0;
    @(negedge clk);
    check("k1_pend", 32'(key_pending), 32'd1);
    check("k1_we", 32'(ram_write_enable), 32'd1);
    tick();
    @(negedge clk);
    check("k1_empty", 32'(key_pending), 32'd0);

    // starvation: CPU loads every cycle
    tick();
    cpu_we    = 1'b1;
    cpu_addr  = 12'h040;
    cpu_wdata = 32'hCAFEF00D;
    push_exp(12'h040, 32'hCAFEF00D);
    tick();
    cpu_we    = 1'b0;
    cpu_re    = 1'b1;
    key_valid = 1'b1;
    key_addr  = 12'h314;
    key_wdata = 32'h42;
    push_exp(12'h314, 32'h42);
    tick();
    key_valid = 1'b0;
    stalls = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("stall_%0d", k), 32'(cpu_stall),
            (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("ld_%0d", k), cpu_rdata,
            (k == 8) ? 32'd0 : 32'hCAFEF00D);
      if (cpu_stall) stalls++;
      tick();
    end
    check("stall_cnt", 32'(stalls), 32'd1);
    check("sv_pend", 32'(key_pending), 32'd0);

    // fill FIFO, overflow, clear
    cpu_addr = 12'h040;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1;
      key_addr  = 12'h320 + 12'(4 * i);
      key_wdata = 32'h50 + 32'(i);
      if (i < 4) push_exp(key_addr, key_wdata);
      if (i == 4) begin
        @(negedge clk);
        check("rdy_full", 32'(key_ready), 32'd0);
        check("pend_full", 32'(key_pending), 32'd4);
      end
      tick();
    end
    key_valid = 1'b0;
    @(negedge clk);
    check("ovf_set", 32'(key_overflow), 32'd1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(key_overflow), 32'd0);
    tick();
    cpu_re = 1'b0;
    drain();

    // same-cycle key write and CPU store
    tick();
    key_valid = 1'b1;
    key_addr  = 12'h100;
    key_wdata = 32'hAA;
    cpu_we    = 1'b1;
    cpu_addr  = 12'h104;
    cpu_wdata = 32'hBB;
    push_exp(12'h104, 32'hBB);
    push_exp(12'h100, 32'hAA);
    @(negedge clk);
    check("cpu_wins", 32'(ram_addr), 32'h104);
    tick();
    key_valid = 1'b0;
    cpu_we    = 1'b0;
    @(negedge clk);
    check("key_next", 32'(ram_addr), 32'h100);
    tick();
    cpu_re   = 1'b1;
    cpu_addr = 12'h100;
    @(negedge clk);
    check("rb_100", cpu_rdata, 32'hAA);
    tick();
    cpu_addr = 12'h104;
    @(negedge clk);
    check("rb_104", cpu_rdata, 32'hBB);

    // reset with entries pending
    tick();
    cpu_addr = 12'h040;
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1;
      key_addr  = 12'h340 + 12'(4 * i);
      key_wdata = 32'h70 + 32'(i);
      tick();
    end
    key_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_pend", 32'(key_pending), 32'd3);
    tick();
    rst_n     = 1'b0;
    cpu_re    = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 12'h3F0;
    cpu_wdata = 32'hDEAD;
    @(negedge clk);
    check("mid_rst_pend", 32'(key_pending), 32'd0);
    tick();
    tick();
    cpu_we = 1'b0;
    rst_n  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_pend", 32'(key_pending), 32'd0);
      check("post_rst_stall", 32'(cpu_stall), 32'd0);
      tick();
    end
    check("rst_no_wr", mem[12'h3F0 >> 2], 32'd0);

    // buffered writes to one word, then an immediate load
    cpu_we    = 1'b1;
    cpu_addr  = 12'h200;
    cpu_wdata = 32'h99;
    push_exp(12'h200, 32'h99);
    tick();
    cpu_we    = 1'b0;
    cpu_re    = 1'b1;
    cpu_addr  = 12'h040;
    key_valid = 1'b1;
    key_addr  = 12'h200;
    key_wdata = 32'h11;
    push_exp(12'h200, 32'h11);
    tick();
    key_wdata = 32'h22;
    push_exp(12'h200, 32'h22);
    tick();
    key_valid = 1'b0;
    cpu_addr  = 12'h200;
    @(negedge clk);
`ifdef RAM_KEY_ARB_FWD_EN
    check("fwd_ld", cpu_rdata, 32'h22);
`else
    check("fwd_ld", cpu_rdata, 32'h99);
`endif
    tick();
    cpu_re = 1'b0;
    drain();
    tick();
    cpu_re = 1'b1;
    @(negedge clk);
    check("final_ld", cpu_rdata, 32'h22);
    tick();
    cpu_re = 1'b0;
    tick();
    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
